// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte sources.
// Each granted byte is held for the transmitter until done or watchdog abort, followed by a one-cycle guard gap.
module uart_tx_arbiter #(
    parameter int SIZE_DATA      = 8,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic                           o_tx_en,
    output logic                           o_fifo_empty,
    output logic [SIZE_DATA-1:0]           o_tx_data,
    input  logic                           i_tx_done,
    output logic [$clog2(NUM_REQ)-1:0]     o_grant_id,
    output logic                           o_busy,
    output logic                           o_timeout
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int WDW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDW-1:0] ID_LAST = IDW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GUARD
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [IDW-1:0]         r_rr_ptr;
    logic [IDW-1:0]         r_grant_id;
    logic [SIZE_DATA-1:0]   r_tx_data;
    logic [WDW-1:0]         r_wdog;

    logic                   w_found;
    logic [IDW-1:0]         w_sel_idx;
    logic [SIZE_DATA-1:0]   w_sel_data;
    logic [NUM_REQ-1:0]     w_ready;
    logic [IDW-1:0]         w_next_ptr;
    logic                   w_accept;
    logic                   w_advance;
    logic                   w_timeout;

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        logic [IDW-1:0] cand;
        w_found   = 1'b0;
        w_sel_idx = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDW'((int'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_found && i_req_valid[cand]) begin
                w_found   = 1'b1;
                w_sel_idx = cand;
            end
        end
    end

    always_comb begin
        w_sel_data = i_req_data[int'(w_sel_idx)*SIZE_DATA +: SIZE_DATA];
    end

    always_comb begin
        w_ready = '0;
        if ((r_state == IDLE) && w_found && !i_rst) begin
            w_ready[w_sel_idx] = 1'b1;
        end
    end

    always_comb begin
        w_next_ptr = (r_grant_id == ID_LAST) ? '0 : r_grant_id + IDW'(1);
    end

    // Completion takes priority over the watchdog when both land in one cycle.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_accept     = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (i_tx_done) begin
                    w_advance    = 1'b1;
                    w_state_next = GUARD;
                end else if (r_wdog == WD_LAST) begin
                    w_timeout    = 1'b1;
                    w_advance    = 1'b1;
                    w_state_next = GUARD;
                end
            end
            GUARD: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_tx_data  <= '0;
            r_wdog     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_tx_data  <= w_sel_data;
                r_grant_id <= w_sel_idx;
                r_wdog     <= '0;
            end else if (r_state == SEND) begin
                r_wdog <= r_wdog + WDW'(1);
            end
            if (w_advance) begin
                r_rr_ptr <= w_next_ptr;
            end
        end
    end

    always_comb begin
        o_req_ready  = w_ready;
        o_tx_en      = (r_state == SEND);
        o_fifo_empty = (r_state != SEND);
        o_busy       = (r_state == SEND) || (r_state == GUARD);
        o_timeout    = w_timeout && !i_rst;
        o_tx_data    = r_tx_data;
        o_grant_id   = r_grant_id;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter: reset, single frame, contention order,
// watchdog abort, done/terminal collision, reset mid-frame, stray done and lone re-grant.
module tb_uart_tx_arbiter;

    localparam int SD = 8;
    localparam int NR = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NR-1:0]  reqValid = '0;
    logic [NR*SD-1:0] reqData = '0;
    logic [NR-1:0]  reqReady;
    logic           txEn;
    logic           fifoEmpty;
    logic [SD-1:0]  txData;
    logic           txDone = 1'b0;
    logic [1:0]     grantId;
    logic           busy;
    logic           timeoutPulse;

    int numCompared = 0;
    int numMismatched = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .SIZE_DATA      (SD),
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (reqValid),
        .i_req_data   (reqData),
        .o_req_ready  (reqReady),
        .o_tx_en      (txEn),
        .o_fifo_empty (fifoEmpty),
        .o_tx_data    (txData),
        .i_tx_done    (txDone),
        .o_grant_id   (grantId),
        .o_busy       (busy),
        .o_timeout    (timeoutPulse)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One step: move to the falling edge, drive inputs, let combinational outputs settle.
    task automatic applyStimulus(input logic [NR-1:0] valid, input logic done, input logic rstIn);
        @(negedge clk);
        reqValid = valid;
        txDone   = done;
        rst      = rstIn;
        #1;
    endtask

    initial begin
        // Reset behaviour
        applyStimulus(4'hF, 1'b0, 1'b1);
        checkOutput("ready_in_reset", 32'(reqReady), 32'h0);
        applyStimulus(4'hF, 1'b0, 1'b1);
        checkOutput("rst_ready", 32'(reqReady), 32'h0);
        checkOutput("rst_tx_en", 32'(txEn), 32'h0);
        checkOutput("rst_fifo_empty", 32'(fifoEmpty), 32'h1);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_timeout", 32'(timeoutPulse), 32'h0);
        checkOutput("rst_grant", 32'(grantId), 32'h0);
        checkOutput("rst_tx_data", 32'(txData), 32'h0);

        // Single request from requester 0
        reqData = 32'h0000_0029;
        applyStimulus(4'h1, 1'b0, 1'b0);
        checkOutput("single_ready", 32'(reqReady), 32'h1);
        applyStimulus(4'h0, 1'b0, 1'b0);
        checkOutput("single_tx_en", 32'(txEn), 32'h1);
        checkOutput("single_fifo_empty", 32'(fifoEmpty), 32'h0);
        checkOutput("single_tx_data", 32'(txData), 32'h29);
        checkOutput("single_busy", 32'(busy), 32'h1);
        checkOutput("single_grant", 32'(grantId), 32'h0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(4'h0, 1'b0, 1'b0);
            checkOutput("single_hold_tx_en", 32'(txEn), 32'h1);
        end
        applyStimulus(4'h0, 1'b1, 1'b0);
        applyStimulus(4'h0, 1'b0, 1'b0);
        checkOutput("single_guard_tx_en", 32'(txEn), 32'h0);
        checkOutput("single_guard_busy", 32'(busy), 32'h1);
        checkOutput("single_guard_fifo_empty", 32'(fifoEmpty), 32'h1);
        applyStimulus(4'h0, 1'b0, 1'b0);
        checkOutput("single_idle_busy", 32'(busy), 32'h0);
        checkOutput("single_idle_tx_data", 32'(txData), 32'h29);

        // Stray done in IDLE changes nothing; pointer stays at 1
        applyStimulus(4'h0, 1'b1, 1'b0);
        applyStimulus(4'h3, 1'b0, 1'b0);
        checkOutput("stray_busy", 32'(busy), 32'h0);
        checkOutput("stray_ready", 32'(reqReady), 32'h2);
        reqValid = 4'h0;
        #1;

        // Contention: all four valid, expect 0,1,2,3,0 with a two-cycle gap
        applyStimulus(4'h0, 1'b0, 1'b1);
        reqData = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        applyStimulus(4'hF, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checkOutput("cont_ready", 32'(reqReady), 32'(1 << (k % 4)));
            applyStimulus(4'hF, 1'b0, 1'b0);
            checkOutput("cont_grant", 32'(grantId), 32'(k % 4));
            checkOutput("cont_tx_data", 32'(txData), 32'(8'hA0 + (k % 4)));
            checkOutput("cont_tx_en", 32'(txEn), 32'h1);
            checkOutput("cont_send_ready", 32'(reqReady), 32'h0);
            applyStimulus(4'hF, 1'b1, 1'b0);
            applyStimulus(4'hF, 1'b0, 1'b0);
            checkOutput("cont_gap1_tx_en", 32'(txEn), 32'h0);
            checkOutput("cont_guard_ready", 32'(reqReady), 32'h0);
            applyStimulus(4'hF, 1'b0, 1'b0);
            checkOutput("cont_gap2_tx_en", 32'(txEn), 32'h0);
        end

        // Watchdog abort on requester 1
        checkOutput("to_ready", 32'(reqReady), 32'h2);
        for (int c = 1; c <= TO; c++) begin
            applyStimulus(4'hF, 1'b0, 1'b0);
            checkOutput("to_pulse", 32'(timeoutPulse), 32'(c == TO));
            if (c == TO) checkOutput("to_tx_en", 32'(txEn), 32'h1);
        end
        applyStimulus(4'hF, 1'b0, 1'b0);
        checkOutput("to_guard_pulse", 32'(timeoutPulse), 32'h0);
        checkOutput("to_guard_busy", 32'(busy), 32'h1);
        checkOutput("to_guard_tx_en", 32'(txEn), 32'h0);
        applyStimulus(4'hF, 1'b0, 1'b0);
        checkOutput("to_next_ready", 32'(reqReady), 32'h4);

        // Done arrives in the watchdog terminal cycle on requester 2
        for (int c = 1; c < TO; c++) begin
            applyStimulus(4'hF, 1'b0, 1'b0);
            checkOutput("sim_pre_pulse", 32'(timeoutPulse), 32'h0);
        end
        applyStimulus(4'hF, 1'b1, 1'b0);
        checkOutput("sim_pulse", 32'(timeoutPulse), 32'h0);
        checkOutput("sim_tx_en", 32'(txEn), 32'h1);
        applyStimulus(4'hF, 1'b0, 1'b0);
        checkOutput("sim_guard_busy", 32'(busy), 32'h1);
        checkOutput("sim_guard_pulse", 32'(timeoutPulse), 32'h0);
        applyStimulus(4'h4, 1'b0, 1'b0);
        checkOutput("sim_wrap_ready", 32'(reqReady), 32'h4);

        // Reset mid-frame with requester 2 granted
        applyStimulus(4'hF, 1'b0, 1'b1);
        checkOutput("rmf_grant", 32'(grantId), 32'h2);
        checkOutput("rmf_tx_data", 32'(txData), 32'hA2);
        checkOutput("rmf_ready_in_reset", 32'(reqReady), 32'h0);
        checkOutput("rmf_pulse_in_reset", 32'(timeoutPulse), 32'h0);
        applyStimulus(4'hF, 1'b0, 1'b0);
        checkOutput("rmf_tx_en", 32'(txEn), 32'h0);
        checkOutput("rmf_fifo_empty", 32'(fifoEmpty), 32'h1);
        checkOutput("rmf_busy", 32'(busy), 32'h0);
        checkOutput("rmf_ready", 32'(reqReady), 32'h1);
        applyStimulus(4'hF, 1'b0, 1'b0);
        checkOutput("rmf_next_grant", 32'(grantId), 32'h0);
        checkOutput("rmf_next_data", 32'(txData), 32'hA0);

        // Lone requester 3 is re-granted right after GUARD
        applyStimulus(4'h8, 1'b1, 1'b0);
        applyStimulus(4'h8, 1'b0, 1'b0);
        applyStimulus(4'h8, 1'b0, 1'b0);
        checkOutput("lone_ready1", 32'(reqReady), 32'h8);
        applyStimulus(4'h8, 1'b0, 1'b0);
        checkOutput("lone_grant", 32'(grantId), 32'h3);
        applyStimulus(4'h8, 1'b1, 1'b0);
        applyStimulus(4'h8, 1'b0, 1'b0);
        checkOutput("lone_guard_tx_en", 32'(txEn), 32'h0);
        applyStimulus(4'h8, 1'b0, 1'b0);
        checkOutput("lone_ready2", 32'(reqReady), 32'h8);
        applyStimulus(4'h0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter SIZE_DATA, default 8: width of one transmit byte.
REQ-002 Parameter NUM_REQ, default 4: number of requesters sharing the transmitter; the legal range is 2..8.
REQ-003 Parameter TIMEOUT_CYCLES, default 200000: i_clk cycles allowed in SEND before abort; must be 2 or more.
REQ-004 i_clk  in  1  single system clock; all logic is on the rising edge.
REQ-005 i_rst  in  1  synchronous active-high reset.
REQ-006 i_req_valid  in  NUM_REQ  per-requester "byte available".
REQ-007 i_req_data  in  NUM_REQ*SIZE_DATA  requester k byte is bits [k*SIZE_DATA +: SIZE_DATA].
REQ-008 o_req_ready  out  NUM_REQ  one-hot accept strobe; a byte transfers when valid and ready are both high on a clock edge.
REQ-009 o_tx_en  out  1  transmitter enable/start.
REQ-010 o_fifo_empty  out  1  drives the transmitter empty input; 0 means a byte is presented.
REQ-011 o_tx_data  out  SIZE_DATA  byte presented to the transmitter.
REQ-012 i_tx_done  in  1  transmitter end-of-frame pulse.
REQ-013 o_grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
REQ-014 o_busy  out  1  high in the SEND and GUARD states.
REQ-015 o_timeout  out  1  one-cycle pulse on a SEND abort.

Function
REQ-016 The FSM shall have three states: IDLE, SEND and GUARD.
REQ-017 In IDLE, the arbiter shall select the first requester with valid high, searching from rr_ptr upward and wrapping modulo NUM_REQ.
REQ-018 In IDLE, o_req_ready shall be the one-hot of the selected requester, combinationally, and all zeros when no valid is high.
REQ-019 On an IDLE edge with a grant, the block shall:
- latch the selected byte into o_tx_data;
- latch the selected index into o_grant_id;
- move to SEND.
REQ-020 In SEND: o_tx_en = 1, o_fifo_empty = 0, o_tx_data held stable, o_req_ready = 0.
REQ-021 In IDLE and GUARD: o_tx_en = 0, o_fifo_empty = 1, and o_tx_data holds its last value.
REQ-022 On i_tx_done = 1 in SEND, the block shall:
- set rr_ptr to (o_grant_id + 1) mod NUM_REQ;
- move to GUARD.
REQ-023 GUARD shall last exactly one cycle and then move to IDLE, so back-to-back frames have at least a 2-cycle o_tx_en low gap.
REQ-024 A watchdog counter shall clear on SEND entry and increment each SEND cycle.
REQ-025 When the watchdog reaches TIMEOUT_CYCLES-1 without i_tx_done, the block shall:
- pulse o_timeout for one cycle;
- advance rr_ptr as in REQ-022;
- move to GUARD.
REQ-026 If i_tx_done and the watchdog terminal count occur in the same cycle, done shall win and o_timeout shall stay 0.
REQ-027 i_tx_done outside SEND shall be ignored.
REQ-028 Deasserting i_req_valid after acceptance shall not affect the frame in progress.
REQ-029 A requester holding valid continuously shall not be granted twice in a row while any other valid is high (round-robin fairness).
REQ-030 With one requester active alone, it shall be re-granted on the first IDLE cycle after GUARD.
REQ-031 Accept-to-SEND latency is one cycle: o_tx_en rises on the edge that accepts the byte.
REQ-032 Worst-case wait for any continuously valid requester is NUM_REQ-1 frames.

Reset
REQ-033 When i_rst = 1 at a clock edge, the block shall:
- enter IDLE;
- set rr_ptr = 0, o_grant_id = 0, o_tx_data = 0 and watchdog = 0;
- drive o_tx_en = 0, o_fifo_empty = 1, o_busy = 0, o_timeout = 0 and o_req_ready = 0.
REQ-034 Reset asserted during SEND shall abort the frame immediately, with no o_timeout and no rr_ptr advance.
REQ-035 o_req_ready shall be 0 in every cycle where i_rst = 1.

Verification
REQ-036 Single request: after reset, req0 presents 0x29 -> o_req_ready = 0001 for one cycle, o_tx_data = 0x29, o_tx_en = 1 until i_tx_done, then GUARD, then IDLE.
REQ-037 Contention: all four valid with bytes 0xA0..0xA3 held -> grant order 0, 1, 2, 3, 0, and o_tx_en low for at least 2 cycles between frames.
REQ-038 Timeout: TIMEOUT_CYCLES = 16 and i_tx_done never pulses -> o_timeout pulses in the 16th SEND cycle and the next grant goes to the following requester.
REQ-039 Simultaneous events: i_tx_done arrives in the watchdog terminal cycle -> o_timeout = 0 and normal completion.
REQ-040 Reset mid-frame: i_rst for 1 cycle during SEND with req2 granted -> o_tx_en = 0 and o_fifo_empty = 1 next cycle, and the next grant comes from requester 0.
REQ-041 Stray done: i_tx_done pulsed in IDLE -> no state or pointer change.
